logic_unit: RTL and testbench
=============================

Name: logic_unit

Overview:
- Parametrised, registered successor to the single-bit NAND gate: WIDTH-bit bitwise logic unit with eight selectable operations.
- Valid/ready handshake on input and output, 2-entry output buffer, per-result status flags, transaction counter.
- Serves as the bitwise-logic slice of the CPU datapath; the ALU wrapper drives it.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, 16, width of the accepted-transaction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  unit can accept an operand set this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- op  input  3  operation select, sampled with the operands.
- out_valid  output  1  result at buffer head valid.
- out_ready  input  1  consumer accepts the head result.
- OUT  output  WIDTH  result at buffer head.
- flag_zero  output  1  head result == 0.
- flag_ones  output  1  head result == all ones.
- flag_par  output  1  XOR-reduction of head result.
- txn_count  output  CNT_W  number of accepted operand sets.

Behaviour:
- Op encoding: 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 PASS A. All operations are bitwise over WIDTH bits; B is ignored for ops 6 and 7.
- Reset (rst_n low, asynchronous): buffer empty, out_valid=0, OUT=0, all flags 0, txn_count=0. in_ready=1 from the first edge after release.
- Accept: in_valid && in_ready at a rising edge. The result and its flags are computed from A, B and op, then written to the buffer tail.
- Latency: the result is visible on OUT with out_valid=1 in the cycle after acceptance when the buffer was empty. There is no combinational path from the inputs to OUT.
- Buffer:
  - 2 entries, FIFO order.
  - in_ready = (count < 2), derived from registered state only. It does not depend on out_ready in the same cycle.
  - out_valid = (count > 0).
  - OUT and the flags always reflect the head entry.
  - Flags are stored per entry, not recomputed from OUT.
- Pop: out_valid && out_ready at a rising edge removes the head. The next entry appears the following cycle.
- Push and pop in the same cycle with count=1: count stays 1, and the new result becomes the head.
- Full (count=2): in_ready=0, so no push occurs even if a pop happens in the same cycle. in_ready returns to 1 the cycle after the pop.
- in_valid while in_ready=0: the operands are ignored and not latched. The source must hold them.
- While out_valid=1 and out_ready=0, OUT and the flags hold stable.
- When empty: OUT and the flags hold their last value. Consumers must qualify them with out_valid.
- txn_count increments by 1 on every accept and wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-operation: buffer contents are discarded at once, and all outputs return to their reset values asynchronously.

Test Plan:
- Truth table, WIDTH=8, A=0xF0, B=0xCC, out_ready=1. Ops 0..7 must yield OUT=0x3F, 0xC0, 0xFC, 0x03, 0x3C, 0xC3, 0x0F, 0xF0, each 1 cycle after accept, with txn_count=8 at the end.
- Flags:
  - op=1, A=0x0F, B=0xF0 -> OUT=0x00, flag_zero=1, flag_par=0.
  - op=2, A=0xFF, B=0x00 -> flag_ones=1.
  - op=7, A=0x01 -> flag_par=1.
- Backpressure: out_ready=0, push 3 sets -> in_ready=0 after 2 accepts, the third is held and not latched, txn_count=2. Raise out_ready -> results pop in order, the third is accepted the cycle after the first pop, txn_count=3.
- Simultaneous push/pop at count=1 -> count stays 1, out_valid stays 1, the new result is at the head the next cycle, no result lost or duplicated.
- Async reset with 2 entries buffered, asserted between edges -> out_valid=0, OUT=0, txn_count=0 immediately. After release, in_ready=1 and a new op=0, A=B=0xFF gives OUT=0x00.
- Counter wrap with CNT_W=4: 17 accepts -> txn_count=1.

Source files
------------

// File: rtl/logic_unit.sv
// rtl/logic_unit.sv - registered WIDTH-bit bitwise logic unit with 2-entry output buffer
module logic_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] OUT,
    output logic             flag_zero,
    output logic             flag_ones,
    output logic             flag_par,
    output logic [CNT_W-1:0] txn_count
);

    // Entry layout: {par, ones, zero, result}
    localparam int EW = WIDTH + 3;

    logic [EW-1:0]    head_q, head_d;
    logic [EW-1:0]    tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] txn_q, txn_d;

    logic [WIDTH-1:0] res;
    logic [EW-1:0]    new_entry;
    logic             push;
    logic             pop;

    always_comb begin
        res = '0;
        case (op)
            3'd0: res = ~(A & B);
            3'd1: res = A & B;
            3'd2: res = A | B;
            3'd3: res = ~(A | B);
            3'd4: res = A ^ B;
            3'd5: res = ~(A ^ B);
            3'd6: res = ~A;
            3'd7: res = A;
            default: res = '0;
        endcase
        new_entry = {^res, &res, ~|res, res};
    end

    assign push = in_valid & in_ready_q;
    assign pop  = (count_q != 2'd0) & out_ready;

    // The head register is only overwritten by a new head, so it keeps the last result when empty
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop && push) begin
            head_d = new_entry;
        end else if (pop) begin
            if (count_q == 2'd2) begin
                head_d = tail_q;
            end
            count_d = count_q - 2'd1;
        end else if (push) begin
            if (count_q == 2'd0) begin
                head_d = new_entry;
            end else begin
                tail_d = new_entry;
            end
            count_d = count_q + 2'd1;
        end
        in_ready_d = (count_d < 2'd2);
        txn_d      = txn_q + CNT_W'(push);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
            txn_q      <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            txn_q      <= txn_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign OUT       = head_q[WIDTH-1:0];
    assign flag_zero = head_q[WIDTH];
    assign flag_ones = head_q[WIDTH+1];
    assign flag_par  = head_q[WIDTH+2];
    assign txn_count = txn_q;

endmodule

// File: tb/tb_logic_unit.sv
// tb/tb_logic_unit.sv - randomized and directed self-checking bench for logic_unit
module tb_logic_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic [2:0] op = 3'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] OUT;
    logic       flag_zero;
    logic       flag_ones;
    logic       flag_par;
    logic [3:0] txn_count;

    int checks = 0;
    int failures = 0;

    logic_unit #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .OUT       (OUT),
        .flag_zero (flag_zero),
        .flag_ones (flag_ones),
        .flag_par  (flag_par),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] r;
        logic       z;
        logic       o;
        logic       p;
    } ent_t;

    ent_t q[$];
    ent_t last = '0;
    int   mcnt = 0;
    bit   ready_ok = 1'b0;

    // Each op is a 2-input truth table indexed by {a_bit, b_bit}
    function automatic ent_t model_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        ent_t e;
        logic [3:0] tbl;
        case (o)
            3'd0: tbl = 4'b0111;
            3'd1: tbl = 4'b1000;
            3'd2: tbl = 4'b1110;
            3'd3: tbl = 4'b0001;
            3'd4: tbl = 4'b0110;
            3'd5: tbl = 4'b1001;
            3'd6: tbl = 4'b0011;
            default: tbl = 4'b1100;
        endcase
        for (int i = 0; i < 8; i++) e.r[i] = tbl[{a[i], b[i]}];
        e.z = (e.r == 8'h00);
        e.o = (e.r == 8'hFF);
        e.p = ($countones(e.r) % 2) == 1;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            bit acc;
            bit pp;
            acc = in_valid && ready_ok && (q.size() < 2);
            pp  = (q.size() > 0) && out_ready;
            if (pp) void'(q.pop_front());
            if (acc) begin
                q.push_back(model_op(op, A, B));
                mcnt = (mcnt + 1) % 16;
            end
            if (q.size() > 0) last = q[0];
            ready_ok = 1'b1;
        end
    end

    always @(negedge rst_n) begin
        q.delete();
        last = '0;
        mcnt = 0;
        ready_ok = 1'b0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            ent_t e;
            e = (q.size() > 0) ? q[0] : last;
            chk("m_in_ready", 32'(in_ready), 32'(ready_ok && (q.size() < 2)));
            chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("m_out", 32'(OUT), 32'(e.r));
            chk("m_flags", 32'({flag_zero, flag_ones, flag_par}), 32'({e.z, e.o, e.p}));
            chk("m_txn", 32'(txn_count), 32'(mcnt));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(OUT), 32'd0);
        chk("rst_flags", 32'({flag_zero, flag_ones, flag_par}), 32'd0);
        chk("rst_txn", 32'(txn_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic one_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        op = o;
        A = a;
        B = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] tt [8];
        bit rp;
        tt = '{8'h3F, 8'hC0, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};

        do_reset();

        // truth table streamed back-to-back
        out_ready = 1'b1;
        A = 8'hF0;
        B = 8'hCC;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            op = 3'(i);
            @(negedge clk);
            chk("tt_out", 32'(OUT), 32'(tt[i]));
            chk("tt_valid", 32'(out_valid), 32'd1);
        end
        chk("tt_txn", 32'(txn_count), 32'd8);
        in_valid = 1'b0;
        @(negedge clk);

        one_op(3'd1, 8'h0F, 8'hF0);
        chk("flag_and_out", 32'(OUT), 32'h00);
        chk("flag_and_zero", 32'(flag_zero), 32'd1);
        chk("flag_and_par", 32'(flag_par), 32'd0);
        one_op(3'd2, 8'hFF, 8'h00);
        chk("flag_or_ones", 32'(flag_ones), 32'd1);
        one_op(3'd7, 8'h01, 8'hAA);
        chk("flag_pass_out", 32'(OUT), 32'h01);
        chk("flag_pass_par", 32'(flag_par), 32'd1);
        @(negedge clk);

        // backpressure
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd4; A = 8'h11; B = 8'h22;
        @(negedge clk);
        op = 3'd1; A = 8'h44; B = 8'h0F;
        @(negedge clk);
        chk("bp_ready_full", 32'(in_ready), 32'd0);
        op = 3'd7; A = 8'h55; B = 8'h00;
        @(negedge clk);
        chk("bp_ready_held", 32'(in_ready), 32'd0);
        chk("bp_txn2", 32'(txn_count), 32'd2);
        chk("bp_head1", 32'(OUT), 32'h33);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_head2", 32'(OUT), 32'h04);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        chk("bp_txn_still2", 32'(txn_count), 32'd2);
        @(negedge clk);
        chk("bp_head3", 32'(OUT), 32'h55);
        chk("bp_txn3", 32'(txn_count), 32'd3);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_hold_last", 32'(OUT), 32'h55);

        // async reset with two entries buffered
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd2; A = 8'h12; B = 8'h30;
        @(negedge clk);
        op = 3'd6;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ar_full", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_out", 32'(OUT), 32'd0);
        chk("ar_txn", 32'(txn_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_in_ready", 32'(in_ready), 32'd1);
        one_op(3'd0, 8'hFF, 8'hFF);
        chk("ar_nand_out", 32'(OUT), 32'h00);
        chk("ar_nand_zero", 32'(flag_zero), 32'd1);
        chk("ar_nand_valid", 32'(out_valid), 32'd1);

        // counter wrap with 4-bit counter
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; op = 3'd5; A = 8'h5A; B = 8'h3C;
        repeat (17) @(negedge clk);
        in_valid = 1'b0;
        chk("wrap_txn", 32'(txn_count), 32'd1);

        // randomized traffic; source holds operands until accepted
        do_reset();
        rp = 1'b0;
        repeat (2000) begin
            @(negedge clk);
            if (!(in_valid && !rp)) begin
                in_valid = ($urandom_range(0, 2) != 0);
                A = 8'($urandom);
                B = 8'($urandom);
                op = 3'($urandom_range(0, 7));
            end
            out_ready = ($urandom_range(0, 1) == 1);
            rp = in_ready;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("drain_empty", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
